// File: rtl/sb_pkg.sv
// Shared types and helpers for the sb_array switch box: side encoding,
// per-track route config word and mod-4 rotation helpers.
package sb_pkg;

  typedef enum logic [1:0] {N = 2'd0, E = 2'd1, S = 2'd2, W = 2'd3} dir_e;

  localparam int CFG_W = 9;

  typedef struct packed {
    logic       mode;
    logic [3:0] dvn;
    logic [3:0] dve;
  } sb_cfg_t;

  function automatic logic [1:0] rot_cw(input logic [1:0] s);
    return s + 2'd1;
  endfunction

  function automatic logic [1:0] rot_ccw(input logic [1:0] s);
    return s - 2'd1;
  endfunction

  // A track is illegal with three or more drivers, or with no driver but
  // sinks requested.
  function automatic logic cfg_err_f(input sb_cfg_t c);
    logic [2:0] k;
    k = 3'(c.dve[0]) + 3'(c.dve[1]) + 3'(c.dve[2]) + 3'(c.dve[3]);
    return (k >= 3'd3) || (k == 3'd0 && |c.dvn);
  endfunction

endpackage

// File: rtl/sb_track_route.sv
// Combinational router for one track: maps the four side inputs to the
// four side outputs/enables from the active config word.
module sb_track_route
  import sb_pkg::*;
(
  input  sb_cfg_t    i_cfg,
  input  logic [3:0] i_in,
  output logic [3:0] o_out,
  output logic [3:0] o_oe,
  output logic       o_err
);

  logic [2:0] w_k;
  logic [1:0] w_a, w_b, w_da, w_db;

  // w_a = lowest driver side, w_b = highest, w_k = driver count
  always_comb begin
    w_k = '0;
    w_a = '0;
    w_b = '0;
    for (int s = 0; s < 4; s++) begin
      if (i_cfg.dve[s]) begin
        if (w_k == 3'd0) w_a = 2'(s);
        w_b = 2'(s);
        w_k = w_k + 3'd1;
      end
    end
  end

  always_comb begin
    o_out = '0;
    o_oe  = '0;
    w_da  = w_a;
    w_db  = w_b;
    if (w_b - w_a == 2'd2) begin
      w_da = i_cfg.mode ? rot_ccw(w_a) : rot_cw(w_a);
      w_db = i_cfg.mode ? rot_ccw(w_b) : rot_cw(w_b);
    end else if (!i_cfg.mode) begin
      w_da = w_a + 2'd2;
      w_db = w_b + 2'd2;
    end else if (w_b - w_a == 2'd1) begin
      w_da = rot_ccw(w_a);
      w_db = rot_cw(w_b);
    end else begin
      // wrap-around pair {W,N}: W is the lower-clockwise side
      w_da = rot_cw(w_a);
      w_db = rot_ccw(w_b);
    end

    case (w_k)
      3'd1: begin
        for (int s = 0; s < 4; s++) begin
          if (2'(s) != w_a && i_cfg.dvn[s]) begin
            o_oe[s]  = 1'b1;
            o_out[s] = i_in[w_a];
          end
        end
      end
      3'd2: begin
        o_oe[w_da]  = 1'b1;
        o_out[w_da] = i_in[w_a];
        o_oe[w_db]  = 1'b1;
        o_out[w_db] = i_in[w_b];
      end
      default: ;
    endcase
  end

  assign o_err = cfg_err_f(i_cfg);

endmodule

// File: rtl/sb_array.sv
// Multi-track switch box: serial shadow config chain, atomic commit to the
// active config, per-track routers. SB_OUTPUT_REG_EN adds output flops.
module sb_array
  import sb_pkg::*;
#(
  parameter int TRACKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic                cfg_in,
  input  logic                cfg_commit,
  output logic                cfg_out,
  output logic                cfg_err,
  input  logic [4*TRACKS-1:0] pin_in,
  output logic [4*TRACKS-1:0] pin_out,
  output logic [4*TRACKS-1:0] pin_oe
);

  localparam int CW = CFG_W * TRACKS;

  logic [CW-1:0]       r_shadow, r_active;
  logic                r_err;
  logic [4*TRACKS-1:0] w_out, w_oe;
  logic [TRACKS-1:0]   w_trk_err, w_sh_err;

  for (genvar t = 0; t < TRACKS; t++) begin : g_trk
    logic [3:0] w_in, w_o, w_e;
    for (genvar s = 0; s < 4; s++) begin : g_side
      assign w_in[s]             = pin_in[s*TRACKS+t];
      assign w_out[s*TRACKS+t]   = w_o[s];
      assign w_oe[s*TRACKS+t]    = w_e[s];
    end
    sb_track_route u_route (
      .i_cfg (sb_cfg_t'(r_active[CFG_W*t +: CFG_W])),
      .i_in  (w_in),
      .o_out (w_o),
      .o_oe  (w_e),
      .o_err (w_trk_err[t])
    );
    assign w_sh_err[t] = cfg_err_f(sb_cfg_t'(r_shadow[CFG_W*t +: CFG_W]));
  end

  // Commit samples the pre-shift shadow; the error flag follows the value
  // being loaded so it is valid on the same edge as the new route.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_err    <= 1'b0;
    end else begin
      if (cfg_commit) r_active <= r_shadow;
      if (cfg_en)     r_shadow <= {cfg_in, r_shadow[CW-1:1]};
      r_err <= cfg_commit ? |w_sh_err : |w_trk_err;
    end
  end

  assign cfg_out = r_shadow[0];
  assign cfg_err = r_err;

`ifdef SB_OUTPUT_REG_EN
  logic [4*TRACKS-1:0] r_out, r_oe;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_oe  <= '0;
    end else begin
      r_out <= w_out;
      r_oe  <= w_oe;
    end
  end
  assign pin_out = r_out;
  assign pin_oe  = r_oe;
`else
  assign pin_out = w_out;
  assign pin_oe  = w_oe;
`endif

endmodule
